truth_table_scanner: RTL and testbench

- Sequencer that drives an external combinational boolean expression block through all 2^N_VARS input vectors.
- Waits a programmable settle time per vector, samples the expression output and builds the full truth table as a bit vector.
- Also counts minterms and compares the result against an expected table.
- Sits between a test/control host (start/abort, results) and one combinational expression instance; replaces hand-written exhaustive stimulus sequences.

---
 rtl/truth_scan_pkg.sv | 16 +
 rtl/guia06_expr.sv | 16 +
 rtl/truth_table_scanner.sv | 95 +++++++++
 tb/tb_truth_table_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_scan_pkg.sv
// Shared definitions for the truth-table scanner: controller state encoding
// and the derivation of the table width from the number of expression inputs.
package truth_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

  function automatic int table_width(input int n_vars);
    return 1 << n_vars;
  endfunction

endpackage

// File: rtl/guia06_expr.sv
// Combinational boolean expression under test: s = (x | ~y) & (~y | ~w).
// z is part of the expression's input vector but does not affect the result.
module guia06_expr (
  output logic s,
  input  logic x,
  input  logic y,
  input  logic w,
  input  logic z
);

  logic unused_z;

  assign unused_z = z;
  assign s = (x | ~y) & (~y | ~w);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks an external combinational expression through every input vector,
// samples its output after a settle time and collects the full truth table.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter  int N_VARS = 4,
  parameter  int SETTLE = 1,
  localparam int TW     = table_width(N_VARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_VARS-1:0] vec,
  input  logic              f_in,
  input  logic [TW-1:0]     expected,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [TW-1:0]     table_out,
  output logic [N_VARS:0]   ones_count,
  output logic              match
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_VARS-1:0] VEC_LAST = {N_VARS{1'b1}};

  scan_state_t   state;
  logic [CW-1:0] cnt;

  // Abort overrides everything outside IDLE; in IDLE it also masks start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      table_out  <= '0;
      ones_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              vec        <= '0;
              table_out  <= '0;
              ones_count <= '0;
              cnt        <= '0;
              valid      <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt == CNT_LAST) begin
              state <= ST_SAMPLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_SAMPLE: begin
            table_out[vec] <= f_in;
            ones_count     <= ones_count + (N_VARS + 1)'(f_in);
            if (vec == VEC_LAST) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              vec   <= vec + N_VARS'(1);
              cnt   <= '0;
              state <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Left combinational so a host can probe several reference tables per scan.
  assign match = valid & (table_out == expected);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: directed scenarios plus random
// truth tables, with a scoreboard queue checked by an independent monitor.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        abort = 1'b0;
  logic        use_expr = 1'b0;
  logic [15:0] ftab = '0;
  logic [15:0] exp_tab = '0;

  logic [3:0]  vec_a, vec_b;
  logic        f_in_a, f_in_b, s_expr;
  logic        busy_a, done_a, valid_a, match_a;
  logic        busy_b, done_b, valid_b, match_b;
  logic [15:0] table_a, table_b;
  logic [4:0]  ones_a, ones_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          which;
    int          done_cyc;
    logic [15:0] tab;
    logic [4:0]  ones;
    logic        m;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   pend = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  guia06_expr u_expr (
    .s(s_expr), .x(vec_a[3]), .y(vec_a[2]), .w(vec_a[1]), .z(vec_a[0])
  );

  assign f_in_a = use_expr ? s_expr : ftab[vec_a];
  assign f_in_b = ftab[vec_b];

  truth_table_scanner #(.N_VARS(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .vec(vec_a),
    .f_in(f_in_a), .expected(exp_tab), .busy(busy_a), .done(done_a),
    .valid(valid_a), .table_out(table_a), .ones_count(ones_a), .match(match_a)
  );

  truth_table_scanner #(.N_VARS(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .vec(vec_b),
    .f_in(f_in_b), .expected(exp_tab), .busy(busy_b), .done(done_b),
    .valid(valid_b), .table_out(table_b), .ones_count(ones_b), .match(match_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: evaluate (x|~y)&(~y|~w) over every index, x being the MSB.
  function automatic logic [15:0] exprModel();
    logic [15:0] t;
    int x, y, w;
    for (int i = 0; i < 16; i++) begin
      x = (i / 8) % 2;
      y = (i / 4) % 2;
      w = (i / 2) % 2;
      t[i] = ((x == 1) || (y == 0)) && ((y == 0) || (w == 0));
    end
    return t;
  endfunction

  task automatic applyStimulus(input int which, input logic [15:0] model, input logic [15:0] exp_in);
    exp_t e;
    @(negedge clk);
    exp_tab = exp_in;
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    e.which    = which;
    e.done_cyc = cyc + 16 * ((which == 0) ? 2 : 4);
    e.tab      = model;
    e.ones     = 5'($countones(model));
    e.m        = (model == exp_in);
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !pend) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("scan_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic checkZeroA(input string tag);
    checkOutput({tag, "_vec"},   {28'd0, vec_a},   32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy_a},  32'd0);
    checkOutput({tag, "_done"},  {31'd0, done_a},  32'd0);
    checkOutput({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    checkOutput({tag, "_table"}, {16'd0, table_a}, 32'd0);
    checkOutput({tag, "_ones"},  {27'd0, ones_a},  32'd0);
    checkOutput({tag, "_match"}, {31'd0, match_a}, 32'd0);
  endtask

  // Monitor: on done check timing, one cycle later check the held results.
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (cur.which == 0) begin
        checkOutput("res_table", {16'd0, table_a}, {16'd0, cur.tab});
        checkOutput("res_ones",  {27'd0, ones_a},  {27'd0, cur.ones});
        checkOutput("res_valid", {31'd0, valid_a}, 32'd1);
        checkOutput("res_busy",  {31'd0, busy_a},  32'd0);
        checkOutput("res_done",  {31'd0, done_a},  32'd0);
        checkOutput("res_match", {31'd0, match_a}, {31'd0, cur.m});
        checkOutput("res_vec",   {28'd0, vec_a},   32'd15);
      end else begin
        checkOutput("res_table", {16'd0, table_b}, {16'd0, cur.tab});
        checkOutput("res_ones",  {27'd0, ones_b},  {27'd0, cur.ones});
        checkOutput("res_valid", {31'd0, valid_b}, 32'd1);
        checkOutput("res_busy",  {31'd0, busy_b},  32'd0);
        checkOutput("res_done",  {31'd0, done_b},  32'd0);
        checkOutput("res_match", {31'd0, match_b}, {31'd0, cur.m});
        checkOutput("res_vec",   {28'd0, vec_b},   32'd15);
      end
    end else if (done_a || done_b) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        cur = sb.pop_front();
        checkOutput("done_cycle", cyc, cur.done_cyc);
        checkOutput("done_src", {31'd0, done_b}, cur.which);
        pend = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] m, r, e;
    int          which;

    #22;
    checkZeroA("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal scan through the real expression, then probe match directly.
    use_expr = 1'b1;
    m = exprModel();
    applyStimulus(0, m, 16'h3F0F);
    waitIdle();
    checkOutput("nominal_table", {16'd0, table_a}, 32'h3F0F);
    exp_tab = 16'h3F0E;
    #1;
    checkOutput("match_off", {31'd0, match_a}, 32'd0);
    exp_tab = 16'h3F0F;
    #1;
    checkOutput("match_on", {31'd0, match_a}, 32'd1);

    // Constant functions.
    use_expr = 1'b0;
    ftab = 16'h0000;
    applyStimulus(0, 16'h0000, 16'h0000);
    waitIdle();
    ftab = 16'hFFFF;
    applyStimulus(0, 16'hFFFF, 16'hFFFF);
    waitIdle();

    // SETTLE=3 identity f=z with vec checked every cycle.
    ftab = 16'hAAAA;
    applyStimulus(1, 16'hAAAA, 16'hAAAA);
    for (int k = 0; k < 64; k++) begin
      checkOutput("vec_hold", {28'd0, vec_b}, k / 4);
      @(posedge clk);
      #1;
    end
    waitIdle();

    // Second start mid-scan must be ignored.
    use_expr = 1'b1;
    applyStimulus(0, m, 16'h3F0F);
    repeat (8) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitIdle();
    repeat (40) @(negedge clk);

    // Abort mid-scan: no done, results unqualified, then a clean rescan.
    applyStimulus(0, m, 16'h3F0F);
    repeat (10) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    checkOutput("abort_busy",  {31'd0, busy_a},  32'd0);
    checkOutput("abort_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("abort_match", {31'd0, match_a}, 32'd0);
    repeat (40) @(negedge clk);
    applyStimulus(0, m, 16'h3F0F);
    waitIdle();

    // Abort together with start in IDLE: abort wins.
    @(negedge clk);
    abort = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start_a = 1'b0;
    checkOutput("abort_start_busy", {31'd0, busy_a}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("abort_start_idle", {31'd0, busy_a}, 32'd0);
    checkOutput("abort_start_valid", {31'd0, valid_a}, 32'd1);

    // Asynchronous reset mid-scan, observed between clock edges.
    applyStimulus(0, m, 16'h3F0F);
    repeat (18) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkZeroA("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, m, 16'h3F0F);
    waitIdle();

    // Random truth tables on either instance, expected table sometimes off by one bit.
    use_expr = 1'b0;
    for (int n = 0; n < 12; n++) begin
      r = 16'($urandom);
      e = ($urandom_range(0, 1) == 1) ? r : (r ^ (16'h0001 << $urandom_range(0, 15)));
      which = $urandom_range(0, 1);
      ftab = r;
      applyStimulus(which, r, e);
      waitIdle();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
